// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one program/data RAM between the processor core (cpu) and the
//   debug/program-loader port (dbg). Every access uses the strobe protocol:
//   the selected RAM clock is driven low for one cycle, then high, and that
//   rising edge performs the access. Requesters hold a level req and receive
//   a one-cycle done pulse; req/we/addr/wdata are sampled only at grant.
//
//   Optional build macro: ARB_FIXED_PRIORITY_EN
//     defined   - dbg always wins a tie (lets the loader stall the cpu)
//     undefined - round-robin between the two requesters
//
// Ports:
//   clock, reset                       system clock, async active-high reset
//   cpu_req/we/addr/wdata              cpu transaction request
//   cpu_rdata, cpu_done                cpu read data, completion pulse
//   dbg_req/we/addr/wdata              debug transaction request
//   dbg_rdata, dbg_done                debug read data, completion pulse
//   ram_read_clock, ram_write_clock    RAM access strobes
//   ram_read_addr, ram_write_addr      RAM addresses
//   ram_data, ram_q                    RAM write data / read data
//   busy                               high whenever a transaction is active
module ram_arbiter #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [WORD_W-1:0] dbg_wdata,
  output logic [WORD_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              ram_read_clock,
  output logic              ram_write_clock,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [WORD_W-1:0] ram_data,
  input  logic [WORD_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, RD_LOW, RD_HIGH, RD_CAP, WR_LOW, WR_HIGH, RELEASE
  } state_t;

  state_t state;
  logic   owner;      // 1 = dbg owns the current transaction
  logic   pick_dbg;   // arbitration result for a grant in IDLE

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick_dbg = dbg_req;
  end
`else
  logic last_owner;   // 1 = dbg was granted last; reset so cpu wins first tie

  always_comb begin
    pick_dbg = dbg_req && (!cpu_req || !last_owner);
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // Strobes reset low: reset can only ever produce a falling strobe edge.
      state           <= IDLE;
      owner           <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_owner      <= 1'b1;
`endif
      cpu_rdata       <= '0;
      cpu_done        <= 1'b0;
      dbg_rdata       <= '0;
      dbg_done        <= 1'b0;
      ram_read_clock  <= 1'b0;
      ram_write_clock <= 1'b0;
      ram_read_addr   <= '0;
      ram_write_addr  <= '0;
      ram_data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            owner <= pick_dbg;
`ifndef ARB_FIXED_PRIORITY_EN
            last_owner <= pick_dbg;
`endif
            ram_read_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
            ram_write_addr <= pick_dbg ? dbg_addr  : cpu_addr;
            ram_data       <= pick_dbg ? dbg_wdata : cpu_wdata;
            state          <= (pick_dbg ? dbg_we : cpu_we) ? WR_LOW : RD_LOW;
          end
        end
        RD_LOW: begin
          ram_read_clock <= 1'b0;
          state          <= RD_HIGH;
        end
        RD_HIGH: begin
          ram_read_clock <= 1'b1;
          state          <= RD_CAP;
        end
        RD_CAP: begin
          if (owner) begin
            dbg_rdata <= ram_q;
            dbg_done  <= 1'b1;
          end else begin
            cpu_rdata <= ram_q;
            cpu_done  <= 1'b1;
          end
          state <= RELEASE;
        end
        WR_LOW: begin
          ram_write_clock <= 1'b0;
          state           <= WR_HIGH;
        end
        WR_HIGH: begin
          ram_write_clock <= 1'b1;
          if (owner) dbg_done <= 1'b1;
          else       cpu_done <= 1'b1;
          state <= RELEASE;
        end
        RELEASE: begin
          // req is deliberately not sampled here.
          cpu_done <= 1'b0;
          dbg_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed vector table, hand-written multi-cycle
// sequences, and a randomized run checked against a transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          cpu_done, dbg_done;
  logic          ram_read_clock, ram_write_clock;
  logic [AW-1:0] ram_read_addr, ram_write_addr;
  logic [DW-1:0] ram_data, ram_q;
  logic          busy;

  int passed = 0;
  int total  = 0;

  ram_arbiter #(.WORD_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .ram_read_clock(ram_read_clock), .ram_write_clock(ram_write_clock),
    .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
    .ram_data(ram_data), .ram_q(ram_q), .busy(busy)
  );

  always #5 clock = ~clock;

  // Strobe-clocked RAM model
  logic [DW-1:0] ram [0:(1<<AW)-1];
  int            wr_count = 0;
  int            rd_count = 0;
  logic [AW-1:0] last_wr_addr = '0;

  always @(posedge ram_read_clock) begin
    ram_q    <= ram[ram_read_addr];
    rd_count <= rd_count + 1;
  end

  always @(posedge ram_write_clock) begin
    ram[ram_write_addr] <= ram_data;
    last_wr_addr        <= ram_write_addr;
    wr_count            <= wr_count + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  typedef struct {
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          rclk, wclk, cdone, ddone, bsy;
    logic [AW-1:0] raddr, waddr;
    logic [DW-1:0] data, crd, drd;
  } vec_t;

  // Model state for the randomized phase
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  int            m_rem;
  logic          m_own, m_last, m_we;
  logic [DW-1:0] m_val, exp_crd, exp_drd;
  logic          ca, cb, da, db;
  int            m_writes, wr_base;

  initial begin
    vec_t          vecs[10];
    logic [120:0]  obs, expv;
    int            n, cyc, d0, d1;
    int            own[3], at[3];
    logic [DW-1:0] old7, old9;
    int            wc0, rc0;

    for (int i = 0; i < (1 << AW); i++) ram[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    reset = 1;
    idle_inputs();
    #1;
    check("reset_outputs",
          {ram_read_clock, ram_write_clock, cpu_done, dbg_done, busy, cpu_rdata, dbg_rdata},
          '0);

    // ---------------- directed vector table ----------------
    //           creq cwe addr wdata   rclk wclk cd dd busy raddr waddr data        crd         drd
    vecs[0] = '{1, 1, 5, 32'h1234, 0, 0, 0, 0, 1, 5, 5, 32'h1234, 0, 0};
    vecs[1] = '{1, 1, 5, 32'h1234, 0, 0, 0, 0, 1, 5, 5, 32'h1234, 0, 0};
    vecs[2] = '{1, 1, 5, 32'h1234, 0, 1, 1, 0, 1, 5, 5, 32'h1234, 0, 0};
    vecs[3] = '{0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 5, 5, 32'h1234, 0, 0};
    vecs[4] = '{1, 0, 5, 32'h0,    0, 1, 0, 0, 1, 5, 5, 32'h0,    0, 0};
    vecs[5] = '{1, 0, 5, 32'h0,    0, 1, 0, 0, 1, 5, 5, 32'h0,    0, 0};
    vecs[6] = '{1, 0, 5, 32'h0,    1, 1, 0, 0, 1, 5, 5, 32'h0,    0, 0};
    vecs[7] = '{0, 0, 0, 32'h0,    1, 1, 1, 0, 1, 5, 5, 32'h0,    32'h1234, 0};
    vecs[8] = '{0, 0, 0, 32'h0,    1, 1, 0, 0, 0, 5, 5, 32'h0,    32'h1234, 0};
    vecs[9] = '{0, 0, 0, 32'h0,    1, 1, 0, 0, 0, 5, 5, 32'h0,    32'h1234, 0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
      @(negedge clock);
      obs  = {ram_read_clock, ram_write_clock, cpu_done, dbg_done, busy,
              ram_read_addr, ram_write_addr, ram_data, cpu_rdata, dbg_rdata};
      expv = {vecs[i].rclk, vecs[i].wclk, vecs[i].cdone, vecs[i].ddone, vecs[i].bsy,
              vecs[i].raddr, vecs[i].waddr, vecs[i].data, vecs[i].crd, vecs[i].drd};
      check($sformatf("vec%0d", i), obs, expv);
    end

    // ---------------- contention from reset ----------------
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 2; dbg_wdata = 32'h77;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clock);
      if (cpu_done && n < 3) begin own[n] = 0; at[n] = c; n++; end
      if (dbg_done && n < 3) begin own[n] = 1; at[n] = c; n++; end
      cpu_req = !cpu_done;
      dbg_req = !dbg_done;
    end
    idle_inputs();
    check("contention_count", n, 3);
    if (n == 3) begin
`ifdef ARB_FIXED_PRIORITY_EN
      check("contention_order", {own[0][0], own[1][0], own[2][0]}, 3'b111);
`else
      check("contention_order", {own[0][0], own[1][0], own[2][0]}, 3'b010);
`endif
      check("contention_gap", at[1] - at[0], 4);
    end

    // ---------------- address change after grant ----------------
    do_reset();
    old7 = ram[7];
    cpu_req = 1; cpu_we = 1; cpu_addr = 3; cpu_wdata = 32'hCAFE;
    @(negedge clock);
    cpu_addr = 7; cpu_wdata = 32'hBAD0;
    d0 = 0;
    for (int c = 0; c < 10 && !d0; c++) begin
      @(negedge clock);
      if (cpu_done) d0 = 1;
    end
    cpu_req = 0;
    check("addrchg_done", d0, 1);
    @(negedge clock);
    check("addrchg_strobe_addr", last_wr_addr, 3);
    check("addrchg_mem3", ram[3], 32'hCAFE);
    check("addrchg_mem7", ram[7], old7);

    // ---------------- reset while write strobe is low ----------------
    do_reset();
    old9 = ram[9];
    wc0 = wr_count; rc0 = rd_count;
    cpu_req = 1; cpu_we = 1; cpu_addr = 9; cpu_wdata = 32'hDEAD;
    @(negedge clock);
    @(negedge clock);
    check("midrst_wclk_low", ram_write_clock, 0);
    #1 reset = 1; cpu_req = 0;
    #1 check("midrst_outputs", {ram_read_clock, ram_write_clock, busy, cpu_done}, 4'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    repeat (4) @(negedge clock);
    check("midrst_no_edges", {wr_count - wc0, rd_count - rc0}, 64'd0);
    check("midrst_mem9", ram[9], old9);
    check("midrst_idle", {busy, cpu_done, dbg_done}, 3'b0);

    // ---------------- back-to-back writes, req held ----------------
    do_reset();
    wc0 = wr_count;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10; cpu_wdata = 32'hA0;
    n = 0; d0 = -1; d1 = -1;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clock);
      if (cpu_done) begin
        if (n == 0) begin d0 = c; cpu_wdata = 32'hB0; end
        else begin d1 = c; cpu_req = 0; end
        n++;
      end
    end
    cpu_req = 0;
    repeat (2) @(negedge clock);
    check("b2b_pulses", n, 2);
    check("b2b_gap", d1 - d0, 4);
    check("b2b_writes", wr_count - wc0, 2);
    check("b2b_mem10", ram[10], 32'hB0);

    // ---------------- randomized run vs transaction model ----------------
    do_reset();
    for (int i = 0; i < (1 << AW); i++) mmem[i] = ram[i];
    m_rem = 0; m_last = 1; m_own = 0; m_we = 0; m_val = '0;
    exp_crd = '0; exp_drd = '0; m_writes = 0; wr_base = wr_count;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      // One model step for the edge just taken, using the inputs driven before it
      if (m_rem == 0) begin
        if (cpu_req || dbg_req) begin
`ifdef ARB_FIXED_PRIORITY_EN
          m_own = dbg_req;
`else
          m_own = (cpu_req && dbg_req) ? !m_last : dbg_req;
`endif
          m_last = m_own;
          m_we   = m_own ? dbg_we : cpu_we;
          if (m_we) begin
            mmem[m_own ? dbg_addr : cpu_addr] = m_own ? dbg_wdata : cpu_wdata;
            m_writes++;
            m_rem = 3;
          end else begin
            m_val = mmem[m_own ? dbg_addr : cpu_addr];
            m_rem = 4;
          end
        end
      end else m_rem--;
      if (m_rem == 1 && !m_we) begin
        if (m_own) exp_drd = m_val; else exp_crd = m_val;
      end
      check("rnd_busy", busy, m_rem > 0);
      check("rnd_cpu_done", cpu_done, m_rem == 1 && !m_own);
      check("rnd_dbg_done", dbg_done, m_rem == 1 && m_own);
      check("rnd_cpu_rdata", cpu_rdata, exp_crd);
      check("rnd_dbg_rdata", dbg_rdata, exp_drd);
      ca = ($urandom_range(0, 3) != 0); cb = $urandom_range(0, 1);
      da = ($urandom_range(0, 3) != 0); db = $urandom_range(0, 1);
      cpu_req = ca; cpu_we = cb; cpu_addr = $urandom_range(0, 15); cpu_wdata = $urandom;
      dbg_req = da; dbg_we = db; dbg_addr = $urandom_range(0, 15); dbg_wdata = $urandom;
    end
    idle_inputs();
    repeat (8) @(negedge clock);
    check("rnd_write_strobes", wr_count - wr_base, m_writes);
    for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), ram[i], mmem[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
